// File: rtl/serv_debug_ctrl.sv
// Debug halt/resume/step controller for a bit-serial RISC-V core.
// State decodes drive the level outputs; the dpc/cause/illegal outputs are registered pulses.
module serv_debug_ctrl #(
   parameter bit HALT_ON_RESET = 1'b0
) (
   input  logic       clk,
   input  logic       i_rst_n,
   input  logic       i_haltreq,
   input  logic       i_resumereq,
   input  logic       i_insn_done,
   input  logic       i_ebreak,
   input  logic       i_dret,
   input  logic       i_ebreakm,
   input  logic       i_step,
   output logic       o_halt_core,
   output logic       o_halted,
   output logic       o_resumeack,
   output logic       o_dpc_wr,
   output logic       o_dpc_sel,
   output logic       o_pc_from_dpc,
   output logic [2:0] o_dcsr_cause,
   output logic       o_dret_illegal
);

   typedef enum logic [2:0] {
      S_RUN       = 3'd0,
      S_HALT_PEND = 3'd1,
      S_HALTED    = 3'd2,
      S_RESUME    = 3'd3,
      S_STEP      = 3'd4
   } state_t;

   localparam state_t     RESET_STATE = HALT_ON_RESET ? S_HALTED : S_RUN;
   localparam logic [2:0] RESET_CAUSE = HALT_ON_RESET ? 3'd5 : 3'd0;

   localparam logic [2:0] CAUSE_EBREAK  = 3'd1;
   localparam logic [2:0] CAUSE_HALTREQ = 3'd3;
   localparam logic [2:0] CAUSE_STEP    = 3'd4;

   state_t     r_state;
   state_t     w_state_nxt;
   logic       r_dpc_wr;
   logic       r_dpc_sel;
   logic [2:0] r_cause;
   logic       r_dret_illegal;
   logic       w_dpc_wr;
   logic       w_dpc_sel;
   logic [2:0] w_cause;
   logic       w_dret_illegal;
   logic       w_ebreak_q;
   logic       w_dret_q;

   assign w_ebreak_q = i_insn_done & i_ebreak & i_ebreakm;
   assign w_dret_q   = i_insn_done & i_dret;

   // State register
   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= RESET_STATE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic; an accepted halt cannot be withdrawn, and haltreq beats resumereq
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_RUN: begin
            if (w_ebreak_q) begin
               w_state_nxt = S_HALTED;
            end else if (i_haltreq) begin
               w_state_nxt = S_HALT_PEND;
            end else begin
               w_state_nxt = S_RUN;
            end
         end
         S_HALT_PEND: begin
            w_state_nxt = i_insn_done ? S_HALTED : S_HALT_PEND;
         end
         S_HALTED: begin
            w_state_nxt = (i_resumereq && !i_haltreq) ? S_RESUME : S_HALTED;
         end
         S_RESUME: begin
            w_state_nxt = i_step ? S_STEP : S_RUN;
         end
         S_STEP: begin
            w_state_nxt = i_insn_done ? S_HALTED : S_STEP;
         end
         default: begin
            w_state_nxt = S_RUN;
         end
      endcase
   end

   // Output decode plus next values of the registered dpc/cause/illegal outputs
   always_comb begin
      o_halt_core    = (r_state == S_HALT_PEND) || (r_state == S_HALTED);
      o_halted       = (r_state == S_HALTED);
      o_resumeack    = (r_state == S_RESUME);
      o_pc_from_dpc  = (r_state == S_RESUME);
      w_dpc_wr       = 1'b0;
      w_dpc_sel      = r_dpc_sel;
      w_cause        = r_cause;
      w_dret_illegal = 1'b0;
      case (r_state)
         S_RUN: begin
            w_dret_illegal = w_dret_q;
            if (w_ebreak_q) begin
               w_dpc_wr  = 1'b1;
               w_dpc_sel = 1'b0;
               w_cause   = CAUSE_EBREAK;
            end else begin
               w_dpc_wr  = 1'b0;
            end
         end
         S_HALT_PEND: begin
            if (i_insn_done) begin
               w_dpc_wr  = 1'b1;
               w_dpc_sel = !w_ebreak_q;
               w_cause   = w_ebreak_q ? CAUSE_EBREAK : CAUSE_HALTREQ;
            end else begin
               w_dpc_wr  = 1'b0;
            end
         end
         S_STEP: begin
            w_dret_illegal = w_dret_q;
            if (i_insn_done) begin
               w_dpc_wr  = 1'b1;
               w_dpc_sel = !w_ebreak_q;
               if (w_ebreak_q) begin
                  w_cause = CAUSE_EBREAK;
               end else if (i_haltreq) begin
                  w_cause = CAUSE_HALTREQ;
               end else begin
                  w_cause = CAUSE_STEP;
               end
            end else begin
               w_dpc_wr  = 1'b0;
            end
         end
         default: begin
            w_dpc_wr       = 1'b0;
            w_dret_illegal = 1'b0;
         end
      endcase
   end

   // Registered pulse and cause outputs
   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_dpc_wr       <= 1'b0;
         r_dpc_sel      <= 1'b0;
         r_cause        <= RESET_CAUSE;
         r_dret_illegal <= 1'b0;
      end else begin
         r_dpc_wr       <= w_dpc_wr;
         r_dpc_sel      <= w_dpc_sel;
         r_cause        <= w_cause;
         r_dret_illegal <= w_dret_illegal;
      end
   end

   assign o_dpc_wr       = r_dpc_wr;
   assign o_dpc_sel      = r_dpc_sel;
   assign o_dcsr_cause   = r_cause;
   assign o_dret_illegal = r_dret_illegal;

endmodule

// File: tb/tb_serv_debug_ctrl.sv
// Table-driven scoreboard bench for serv_debug_ctrl, plus reset corner sequences
// and a second instance built with HALT_ON_RESET=1.
module tb_serv_debug_ctrl;

   // in  = {haltreq, resumereq, insn_done, ebreak, dret, ebreakm, step}
   // exp = {halt_core, halted, resumeack, dpc_wr, dpc_sel, pc_from_dpc, cause[2:0], dret_illegal}
   typedef struct packed {
      logic [6:0] in;
      logic [9:0] exp;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic rst1_n = 1'b0;
   logic haltreq = 1'b0, resumereq = 1'b0, insn_done = 1'b0, ebreak = 1'b0;
   logic dret = 1'b0, ebreakm = 1'b0, step = 1'b0;

   logic       hc0, hd0, ack0, wr0, sel0, pcd0, ill0;
   logic [2:0] cause0;
   logic       hc1, hd1, ack1, wr1, sel1, pcd1, ill1;
   logic [2:0] cause1;
   logic [9:0] out0, out1;

   int checks = 0;
   int failures = 0;
   vec_t tbl[$];
   logic [9:0] sb[$];

   always #5 clk = ~clk;

   serv_debug_ctrl #(.HALT_ON_RESET(1'b0)) dut0 (
      .clk(clk), .i_rst_n(rst_n), .i_haltreq(haltreq), .i_resumereq(resumereq),
      .i_insn_done(insn_done), .i_ebreak(ebreak), .i_dret(dret), .i_ebreakm(ebreakm),
      .i_step(step), .o_halt_core(hc0), .o_halted(hd0), .o_resumeack(ack0),
      .o_dpc_wr(wr0), .o_dpc_sel(sel0), .o_pc_from_dpc(pcd0), .o_dcsr_cause(cause0),
      .o_dret_illegal(ill0)
   );

   serv_debug_ctrl #(.HALT_ON_RESET(1'b1)) dut1 (
      .clk(clk), .i_rst_n(rst1_n), .i_haltreq(haltreq), .i_resumereq(resumereq),
      .i_insn_done(insn_done), .i_ebreak(ebreak), .i_dret(dret), .i_ebreakm(ebreakm),
      .i_step(step), .o_halt_core(hc1), .o_halted(hd1), .o_resumeack(ack1),
      .o_dpc_wr(wr1), .o_dpc_sel(sel1), .o_pc_from_dpc(pcd1), .o_dcsr_cause(cause1),
      .o_dret_illegal(ill1)
   );

   assign out0 = {hc0, hd0, ack0, wr0, sel0, pcd0, cause0, ill0};
   assign out1 = {hc1, hd1, ack1, wr1, sel1, pcd1, cause1, ill1};

   // dpc_sel only has meaning while dpc_wr is expected
   task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
      logic [9:0] mask;
      mask = exp[6] ? 10'h3ff : 10'b1111011111;
      checks++;
      if ((act & mask) !== (exp & mask)) begin
         failures++;
         $display("FAIL %s actual=%b expected=%b", name, act, exp);
      end
   endtask

   task automatic drive(input logic [6:0] in);
      {haltreq, resumereq, insn_done, ebreak, dret, ebreakm, step} = in;
   endtask

   task automatic apply(input vec_t v, input string name);
      logic [9:0] e;
      @(negedge clk);
      drive(v.in);
      sb.push_back(v.exp);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check(name, out0, e);
   endtask

   initial begin
      // main sequence, starting in RUN after reset
      tbl.push_back({7'b1000000, 10'b1_0_0_0_0_0_000_0}); // haltreq -> HALT_PEND
      tbl.push_back({7'b1000000, 10'b1_0_0_0_0_0_000_0});
      tbl.push_back({7'b0000000, 10'b1_0_0_0_0_0_000_0}); // haltreq dropped, still pending
      tbl.push_back({7'b0010000, 10'b1_1_0_1_1_0_011_0}); // retire -> HALTED cause 3
      tbl.push_back({7'b0000000, 10'b1_1_0_0_0_0_011_0});
      tbl.push_back({7'b1100000, 10'b1_1_0_0_0_0_011_0}); // resume+halt: stay halted
      tbl.push_back({7'b0100000, 10'b0_0_1_0_0_1_011_0}); // RESUME
      tbl.push_back({7'b0000000, 10'b0_0_0_0_0_0_011_0}); // RUN
      tbl.push_back({7'b0011010, 10'b1_1_0_1_0_0_001_0}); // ebreak, ebreakm=1
      tbl.push_back({7'b0100000, 10'b0_0_1_0_0_1_001_0});
      tbl.push_back({7'b0000000, 10'b0_0_0_0_0_0_001_0});
      tbl.push_back({7'b0011000, 10'b0_0_0_0_0_0_001_0}); // ebreak, ebreakm=0
      tbl.push_back({7'b0010100, 10'b0_0_0_0_0_0_001_1}); // dret in RUN
      tbl.push_back({7'b0000000, 10'b0_0_0_0_0_0_001_0});
      tbl.push_back({7'b1000000, 10'b1_0_0_0_0_0_001_0});
      tbl.push_back({7'b0010000, 10'b1_1_0_1_1_0_011_0});
      tbl.push_back({7'b0100001, 10'b0_0_1_0_0_1_011_0}); // resume with step
      tbl.push_back({7'b0000001, 10'b0_0_0_0_0_0_011_0}); // STEP
      tbl.push_back({7'b0000001, 10'b0_0_0_0_0_0_011_0});
      tbl.push_back({7'b0010001, 10'b1_1_0_1_1_0_100_0}); // step done -> cause 4
      tbl.push_back({7'b0000000, 10'b1_1_0_0_0_0_100_0});
      tbl.push_back({7'b0100001, 10'b0_0_1_0_0_1_100_0});
      tbl.push_back({7'b0000001, 10'b0_0_0_0_0_0_100_0});
      tbl.push_back({7'b1010001, 10'b1_1_0_1_1_0_011_0}); // step + haltreq -> cause 3
      tbl.push_back({7'b0000000, 10'b1_1_0_0_0_0_011_0});
      tbl.push_back({7'b0100000, 10'b0_0_1_0_0_1_011_0});
      tbl.push_back({7'b1000000, 10'b0_0_0_0_0_0_011_0}); // haltreq ignored in RESUME
      tbl.push_back({7'b0100000, 10'b0_0_0_0_0_0_011_0}); // resumereq ignored in RUN
      tbl.push_back({7'b1000000, 10'b1_0_0_0_0_0_011_0});
      tbl.push_back({7'b1011010, 10'b1_1_0_1_0_0_001_0}); // pending + ebreak -> cause 1
      tbl.push_back({7'b0100001, 10'b0_0_1_0_0_1_001_0});
      tbl.push_back({7'b0000001, 10'b0_0_0_0_0_0_001_0}); // STEP

      // both instances held in reset
      #12;
      check("reset0", out0, 10'b0_0_0_0_0_0_000_0);
      check("reset1", out1, 10'b1_1_0_0_0_0_101_0);
      @(negedge clk);
      rst_n = 1'b1;
      rst1_n = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk);
         #1;
         check($sformatf("halt_on_reset%0d", i), out1, 10'b1_1_0_0_0_0_101_0);
      end
      rst1_n = 1'b0;

      for (int i = 0; i < tbl.size(); i++) begin
         apply(tbl[i], $sformatf("vec%0d", i));
      end

      // asynchronous reset in the middle of STEP
      #2;
      rst_n = 1'b0;
      #1;
      check("async_reset_step", out0, 10'b0_0_0_0_0_0_000_0);
      @(negedge clk);
      rst_n = 1'b1;
      apply({7'b0000000, 10'b0_0_0_0_0_0_000_0}, "after_reset_run");
      apply({7'b1000000, 10'b1_0_0_0_0_0_000_0}, "rehalt_pend");
      apply({7'b0010000, 10'b1_1_0_1_1_0_011_0}, "rehalted");

      // asynchronous reset while halted
      #2;
      rst_n = 1'b0;
      #1;
      check("async_reset_halted", out0, 10'b0_0_0_0_0_0_000_0);
      @(negedge clk);
      rst_n = 1'b1;
      apply({7'b0000000, 10'b0_0_0_0_0_0_000_0}, "after_reset2");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
